// File: rtl/phase_sequencer.sv
// Traffic-light phase timer: steps through NUM_PHASES programmable-length phases,
// optionally inserting a pedestrian phase at the end of a cycle.
module phase_sequencer #(
  parameter int unsigned      NUM_PHASES  = 4,
  parameter int unsigned      CNT_W       = 8,
  parameter logic [CNT_W-1:0] DEFAULT_DUR = CNT_W'(5),
  parameter logic [CNT_W-1:0] PED_DUR     = CNT_W'(7),
  parameter int unsigned      IDX_W       = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_a_n,
  input  logic                  tick,
  input  logic                  run,
  input  logic                  clr,
  input  logic                  ped_req,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [CNT_W-1:0]      cfg_dur,
  output logic [NUM_PHASES-1:0] phase_oh,
  output logic [IDX_W-1:0]      phase_idx,
  output logic                  ped_en,
  output logic                  all_stop,
  output logic [CNT_W-1:0]      remaining,
  output logic                  phase_start,
  output logic                  cycle_done,
  output logic                  ped_pend
);

  localparam int unsigned      IDX_SPAN = 1 << IDX_W;
  localparam logic [IDX_SPAN-1:0] IDX_OK = IDX_SPAN'((64'(1) << NUM_PHASES) - 64'(1));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PED, S_PAUSE} state_t;

  state_t           state;
  logic             ret_ped;
  logic [CNT_W-1:0] dur_q [NUM_PHASES];
  logic [IDX_W-1:0] next_idx;
  logic [CNT_W-1:0] dur0_ld;
  logic [CNT_W-1:0] next_ld;
  logic [CNT_W-1:0] ped_ld;

  // A programmed duration of zero still occupies one tick.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] d);
    return (d == '0) ? ONE : d;
  endfunction

  assign next_idx = phase_idx + IDX_W'(1);
  assign dur0_ld  = load_val(dur_q[0]);
  assign next_ld  = load_val(dur_q[next_idx]);
  assign ped_ld   = load_val(PED_DUR);

  // Duration registers; survive clr, only reset restores defaults.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      for (int i = 0; i < int'(NUM_PHASES); i++) dur_q[i] <= DEFAULT_DUR;
    end else if (cfg_we && IDX_OK[cfg_idx]) begin
      dur_q[cfg_idx] <= cfg_dur;
    end
  end

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state       <= S_IDLE;
      ret_ped     <= 1'b0;
      phase_oh    <= '0;
      phase_idx   <= '0;
      ped_en      <= 1'b0;
      all_stop    <= 1'b1;
      remaining   <= '0;
      phase_start <= 1'b0;
      cycle_done  <= 1'b0;
      ped_pend    <= 1'b0;
    end else begin
      phase_start <= 1'b0;
      cycle_done  <= 1'b0;
      if (clr) begin
        state     <= S_IDLE;
        ret_ped   <= 1'b0;
        phase_oh  <= '0;
        phase_idx <= '0;
        ped_en    <= 1'b0;
        all_stop  <= 1'b1;
        remaining <= '0;
        ped_pend  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (run) begin
              state       <= S_RUN;
              phase_idx   <= '0;
              phase_oh    <= NUM_PHASES'(1);
              remaining   <= dur0_ld;
              phase_start <= 1'b1;
              all_stop    <= 1'b0;
            end
          end
          S_RUN: begin
            if (ped_req) ped_pend <= 1'b1;
            if (!run) begin
              state   <= S_PAUSE;
              ret_ped <= 1'b0;
            end else if (tick) begin
              if (remaining > ONE) begin
                remaining <= remaining - ONE;
              end else begin
                phase_start <= 1'b1;
                if (phase_idx != LAST_IDX) begin
                  phase_idx <= next_idx;
                  phase_oh  <= phase_oh << 1;
                  remaining <= next_ld;
                end else if (ped_pend || ped_req) begin
                  // Late request on the final tick is still served this cycle.
                  state     <= S_PED;
                  phase_oh  <= '0;
                  ped_en    <= 1'b1;
                  remaining <= ped_ld;
                  ped_pend  <= 1'b0;
                end else begin
                  phase_idx  <= '0;
                  phase_oh   <= NUM_PHASES'(1);
                  remaining  <= dur0_ld;
                  cycle_done <= 1'b1;
                end
              end
            end
          end
          S_PED: begin
            if (!run) begin
              state   <= S_PAUSE;
              ret_ped <= 1'b1;
            end else if (tick) begin
              if (remaining > ONE) begin
                remaining <= remaining - ONE;
              end else begin
                state       <= S_RUN;
                ped_en      <= 1'b0;
                phase_idx   <= '0;
                phase_oh    <= NUM_PHASES'(1);
                remaining   <= dur0_ld;
                phase_start <= 1'b1;
                cycle_done  <= 1'b1;
              end
            end
          end
          S_PAUSE: begin
            if (ped_req && !ret_ped) ped_pend <= 1'b1;
            if (run) state <= ret_ped ? S_PED : S_RUN;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: expected phase starts are queued by the
// stimulus thread and popped by a monitor on every phase_start pulse.
module tb_phase_sequencer;

  logic       clk;
  logic       rst_a_n;
  logic       tick, run, clr, ped_req, cfg_we;
  logic [1:0] cfg_idx;
  logic [7:0] cfg_dur;
  logic [3:0] phase_oh;
  logic [1:0] phase_idx;
  logic       ped_en, all_stop, phase_start, cycle_done, ped_pend;
  logic [7:0] remaining;

  logic       run3, cfg_we3, zero3;
  logic [1:0] cfg_idx3;
  logic [7:0] cfg_dur3;
  logic [2:0] phase_oh3;
  logic [1:0] phase_idx3;
  logic       ped_en3, all_stop3, phase_start3, cycle_done3, ped_pend3;
  logic [7:0] remaining3;

  typedef struct {
    bit ped;
    int idx;
    int rem;
    bit cyc;
    int len;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   tick_cnt = 0;
  int   tick_base = 0;
  bit   ps_d = 0;
  bit   cd_d = 0;

  phase_sequencer u_dut (
    .clk(clk), .rst_a_n(rst_a_n), .tick(tick), .run(run), .clr(clr),
    .ped_req(ped_req), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_dur(cfg_dur),
    .phase_oh(phase_oh), .phase_idx(phase_idx), .ped_en(ped_en),
    .all_stop(all_stop), .remaining(remaining), .phase_start(phase_start),
    .cycle_done(cycle_done), .ped_pend(ped_pend)
  );

  phase_sequencer #(.NUM_PHASES(3)) u_dut3 (
    .clk(clk), .rst_a_n(rst_a_n), .tick(tick), .run(run3), .clr(clr),
    .ped_req(zero3), .cfg_we(cfg_we3), .cfg_idx(cfg_idx3), .cfg_dur(cfg_dur3),
    .phase_oh(phase_oh3), .phase_idx(phase_idx3), .ped_en(ped_en3),
    .all_stop(all_stop3), .remaining(remaining3), .phase_start(phase_start3),
    .cycle_done(cycle_done3), .ped_pend(ped_pend3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push(input bit ped, input int idx, input int rem,
                               input bit cyc, input int len);
    exp_t e;
    e.ped = ped; e.idx = idx; e.rem = rem; e.cyc = cyc; e.len = len;
    sb.push_back(e);
  endfunction

  // Ticks the sequencer actually consumed (run high, not being cleared).
  always @(posedge clk) begin
    if (rst_a_n && tick && run && !clr) tick_cnt++;
  end

  // Monitor: invariants every cycle, scoreboard compare on every phase start.
  always @(negedge clk) begin
    exp_t e;
    int   exp_oh;
    if (rst_a_n) begin
      chk("one_of_stop_ped_light", $countones({all_stop, ped_en, |phase_oh}), 1);
      if (ps_d) chk("phase_start_width", int'(phase_start), 0);
      if (cd_d) chk("cycle_done_width", int'(cycle_done), 0);
      if (cycle_done && !phase_start) chk("cycle_done_without_start", 1, 0);
      if (phase_start) begin
        if (sb.size() == 0) begin
          chk("unexpected_phase_start", 1, 0);
        end else begin
          e = sb.pop_front();
          exp_oh = e.ped ? 0 : (1 << e.idx);
          chk("sb_ped_en", int'(ped_en), int'(e.ped));
          chk("sb_phase_oh", int'(phase_oh), exp_oh);
          if (!e.ped) chk("sb_phase_idx", int'(phase_idx), e.idx);
          chk("sb_remaining", int'(remaining), e.rem);
          chk("sb_cycle_done", int'(cycle_done), int'(e.cyc));
          if (e.len >= 0) chk("sb_prev_phase_ticks", tick_cnt - tick_base, e.len);
        end
        tick_base = tick_cnt;
      end
      ps_d = phase_start;
      cd_d = cycle_done;
    end else begin
      ps_d = 1'b0;
      cd_d = 1'b0;
    end
  end

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc1();
      tick = 1'b0;
      repeat (3) cyc1();
    end
  endtask

  task automatic cfg_write(input int idx, input int val);
    cfg_we  = 1'b1;
    cfg_idx = 2'(idx);
    cfg_dur = 8'(val);
    cyc1();
    cfg_we  = 1'b0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_all_stop"}, int'(all_stop), 1);
    chk({tag, "_phase_oh"}, int'(phase_oh), 0);
    chk({tag, "_phase_idx"}, int'(phase_idx), 0);
    chk({tag, "_ped_en"}, int'(ped_en), 0);
    chk({tag, "_remaining"}, int'(remaining), 0);
    chk({tag, "_ped_pend"}, int'(ped_pend), 0);
    chk({tag, "_phase_start"}, int'(phase_start), 0);
    chk({tag, "_cycle_done"}, int'(cycle_done), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a_n = 1'b0; tick = 1'b0; run = 1'b0; clr = 1'b0; ped_req = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_dur = '0;
    run3 = 1'b0; cfg_we3 = 1'b0; cfg_idx3 = '0; cfg_dur3 = '0; zero3 = 1'b0;
    repeat (3) cyc1();
    chk_cleared("in_reset");
    rst_a_n = 1'b1;
    cyc1();
    chk_cleared("after_reset");

    // Out-of-range index on the 3-phase instance must not touch any register.
    cfg_we3 = 1'b1; cfg_idx3 = 2'd3; cfg_dur3 = 8'd2;
    cyc1();
    cfg_we3 = 1'b0;

    // Default cycle: four phases of 5 ticks, wrap raises cycle_done.
    push(0, 0, 5, 0, -1);
    push(0, 1, 5, 0, 5); push(0, 2, 5, 0, 5); push(0, 3, 5, 0, 5);
    push(0, 0, 5, 1, 5);
    run = 1'b1;
    cyc1();
    tick_n(20);

    // dur[1]=3, dur[2]=0 (behaves as one tick, shows remaining 1).
    cfg_write(2, 0);
    cfg_write(1, 3);
    push(0, 1, 3, 0, 5); push(0, 2, 1, 0, 3); push(0, 3, 5, 0, 1);
    push(0, 0, 5, 1, 5);
    tick_n(14);

    // Pedestrian request during phase 1, served after phase 3.
    push(0, 1, 3, 0, 5);
    tick_n(5);
    ped_req = 1'b1;
    cyc1();
    ped_req = 1'b0;
    chk("ped_pend_latched", int'(ped_pend), 1);
    push(0, 2, 1, 0, 3); push(0, 3, 5, 0, 1); push(1, 0, 7, 0, 5);
    push(0, 0, 5, 1, 7);
    tick_n(16);
    chk("ped_pend_served", int'(ped_pend), 0);
    chk("ped_en_after_ped", int'(ped_en), 0);

    // Pause with remaining=3 in phase 2; ticks ignored, resume without pulse.
    cfg_write(2, 5);
    push(0, 1, 3, 0, 5); push(0, 2, 5, 0, 3);
    tick_n(8);
    tick_n(2);
    chk("pre_pause_remaining", int'(remaining), 3);
    run = 1'b0;
    tick_n(10);
    chk("pause_remaining", int'(remaining), 3);
    chk("pause_phase_idx", int'(phase_idx), 2);
    chk("pause_phase_oh", int'(phase_oh), 4);
    run = 1'b1;
    cyc1();
    chk("resume_remaining", int'(remaining), 3);
    chk("resume_no_start", int'(phase_start), 0);
    push(0, 3, 5, 0, 5);
    tick_n(3);
    chk("after_resume_idx", int'(phase_idx), 3);

    // clr in the middle of a pedestrian phase; programmed dur[1]=3 survives.
    ped_req = 1'b1;
    cyc1();
    ped_req = 1'b0;
    push(1, 0, 7, 0, 5);
    tick_n(5);
    chk("in_ped_ped_en", int'(ped_en), 1);
    tick_n(3);
    push(0, 0, 5, 0, -1); push(0, 1, 3, 0, 5);
    clr = 1'b1;
    cyc1();
    clr = 1'b0;
    chk_cleared("after_clr");
    cyc1();
    tick_n(5);

    // Async reset mid-phase; duration registers return to default.
    tick_n(1);
    rst_a_n = 1'b0;
    #1;
    chk_cleared("async_reset");
    push(0, 0, 5, 0, -1); push(0, 1, 5, 0, 5);
    cyc1();
    rst_a_n = 1'b1;
    cyc1();
    tick_n(5);

    // ped_req coincident with the final tick of phase 3 still enters PED.
    push(0, 2, 5, 0, 5); push(0, 3, 5, 0, 5);
    tick_n(10);
    tick_n(4);
    push(1, 0, 7, 0, 5); push(0, 0, 5, 1, 7);
    ped_req = 1'b1; tick = 1'b1;
    cyc1();
    ped_req = 1'b0; tick = 1'b0;
    chk("late_req_ped_en", int'(ped_en), 1);
    chk("late_req_pend_clear", int'(ped_pend), 0);
    repeat (3) cyc1();
    // A request during PED is dropped: the following cycle wraps normally.
    ped_req = 1'b1;
    cyc1();
    ped_req = 1'b0;
    chk("req_in_ped_ignored", int'(ped_pend), 0);
    tick_n(7);
    push(0, 1, 5, 0, 5); push(0, 2, 5, 0, 5); push(0, 3, 5, 0, 5);
    push(0, 0, 5, 1, 5);
    tick_n(20);

    // 3-phase instance: all phases keep the default after the ignored write.
    run = 1'b0;
    run3 = 1'b1;
    cyc1();
    chk("p3_start_idx", int'(phase_idx3), 0);
    chk("p3_start_oh", int'(phase_oh3), 1);
    chk("p3_start_rem", int'(remaining3), 5);
    for (int k = 1; k <= 3; k++) begin
      tick_n(5);
      chk("p3_idx", int'(phase_idx3), k % 3);
      chk("p3_rem", int'(remaining3), 5);
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
